load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 159 +++++++++++++++
 tb/tb_load_store_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, aligned accesses in a single cycle,
// misaligned half/word accesses serialised into byte accesses, little-endian.
module load_store_unit #(
   parameter int MP_WIDTH = 32
) (
   input  logic                iclk,
   input  logic                irst,
   input  logic                ivalid,
   output logic                oready,
   input  logic                iwe,
   input  logic [2:0]          ifunct3,
   input  logic [MP_WIDTH-1:0] iaddr,
   input  logic [MP_WIDTH-1:0] iwdata,
   output logic                ovalid,
   output logic [MP_WIDTH-1:0] ordata,
   output logic                oerr,
   output logic [MP_WIDTH-1:0] omem_pos,
   output logic                omem_wen,
   output logic [1:0]          omem_be,
   output logic [MP_WIDTH-1:0] omem_wdata,
   input  logic [MP_WIDTH-1:0] imem_rdata
);

   typedef enum logic [1:0] {IDLE, SINGLE, SERIAL, RESP} state_t;

   state_t              r_state;
   logic                r_we;
   logic [2:0]          r_f3;
   logic [MP_WIDTH-1:0] r_addr;
   logic [MP_WIDTH-1:0] r_wdata;
   logic [1:0]          r_cnt;
   logic [1:0]          r_last;
   logic [MP_WIDTH-1:0] r_data;
   logic                r_ovalid;
   logic                r_oerr;
   logic [MP_WIDTH-1:0] r_ordata;

   logic                w_legal;
   logic                w_cross;
   logic [MP_WIDTH-1:0] w_pos;
   logic [7:0]          w_rbyte;
   logic [7:0]          w_wbyte;
   logic [MP_WIDTH-1:0] w_capture;
   logic [MP_WIDTH-1:0] w_ext;
   logic                w_wen;

   always_comb begin
      if (iwe) w_legal = (ifunct3 == 3'b000) || (ifunct3 == 3'b001) || (ifunct3 == 3'b010);
      else     w_legal = (ifunct3 != 3'b011) && (ifunct3 != 3'b110) && (ifunct3 != 3'b111);
   end

   // funct3[1:0] doubles as the size code for every legal request
   assign w_cross = ((ifunct3[1:0] == 2'b01) && (iaddr[1:0] == 2'b11)) ||
                    ((ifunct3[1:0] == 2'b10) && (iaddr[1:0] != 2'b00));

   assign w_pos   = r_addr + MP_WIDTH'(r_cnt);
   assign w_rbyte = imem_rdata[{w_pos[1:0], 3'b000} +: 8];
   assign w_wbyte = r_wdata[{r_cnt, 3'b000} +: 8];

   always_comb begin
      w_capture = r_data;
      if (r_state == SINGLE)
         w_capture = imem_rdata >> {r_addr[1:0], 3'b000};
      else if (r_state == SERIAL)
         w_capture = r_data | (MP_WIDTH'(w_rbyte) << {r_cnt, 3'b000});
   end

   always_comb begin
      case (r_f3)
         3'b000:  w_ext = {{(MP_WIDTH-8){w_capture[7]}}, w_capture[7:0]};
         3'b001:  w_ext = {{(MP_WIDTH-16){w_capture[15]}}, w_capture[15:0]};
         3'b100:  w_ext = {{(MP_WIDTH-8){1'b0}}, w_capture[7:0]};
         3'b101:  w_ext = {{(MP_WIDTH-16){1'b0}}, w_capture[15:0]};
         default: w_ext = w_capture;
      endcase
   end

   always_ff @(posedge iclk) begin
      if (irst) begin
         r_state  <= IDLE;
         r_we     <= 1'b0;
         r_f3     <= '0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_cnt    <= '0;
         r_last   <= '0;
         r_data   <= '0;
         r_ovalid <= 1'b0;
         r_oerr   <= 1'b0;
         r_ordata <= '0;
      end else begin
         r_ovalid <= 1'b0;
         r_oerr   <= 1'b0;
         r_ordata <= '0;
         case (r_state)
            IDLE: if (ivalid) begin
               r_we    <= iwe;
               r_f3    <= ifunct3;
               r_addr  <= iaddr;
               r_wdata <= iwdata;
               r_cnt   <= '0;
               r_data  <= '0;
               r_last  <= (ifunct3[1:0] == 2'b01) ? 2'd1 : 2'd3;
               if (!w_legal) begin
                  r_state  <= RESP;
                  r_ovalid <= 1'b1;
                  r_oerr   <= 1'b1;
               end else if (w_cross) begin
                  r_state <= SERIAL;
               end else begin
                  r_state <= SINGLE;
               end
            end
            SINGLE: begin
               r_data   <= w_capture;
               r_state  <= RESP;
               r_ovalid <= 1'b1;
               r_ordata <= r_we ? '0 : w_ext;
            end
            SERIAL: begin
               r_data <= w_capture;
               r_cnt  <= r_cnt + 2'd1;
               if (r_cnt == r_last) begin
                  r_state  <= RESP;
                  r_ovalid <= 1'b1;
                  r_ordata <= r_we ? '0 : w_ext;
               end
            end
            RESP:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   always_comb begin
      omem_pos   = '0;
      omem_be    = 2'b00;
      omem_wdata = '0;
      w_wen      = 1'b0;
      if (r_state == SINGLE) begin
         omem_pos   = r_addr;
         omem_be    = r_f3[1:0];
         omem_wdata = r_wdata;
         w_wen      = r_we;
      end else if (r_state == SERIAL) begin
         omem_pos   = w_pos;
         omem_wdata = MP_WIDTH'(w_wbyte);
         w_wen      = r_we;
      end
   end

   // Reset gates the strobe immediately so an aborted access writes nothing more
   assign omem_wen = w_wen & ~irst;
   assign oready   = (r_state == IDLE) & ~irst;
   assign ovalid   = r_ovalid;
   assign oerr     = r_oerr;
   assign ordata   = r_ordata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: byte-addressed memory model, response and
// write-strobe scoreboards checked by a negedge monitor.
module tb_load_store_unit;

   logic        iclk = 1'b0;
   logic        irst = 1'b1;
   logic        ivalid = 1'b0;
   logic        iwe = 1'b0;
   logic [2:0]  ifunct3 = 3'b000;
   logic [31:0] iaddr = '0;
   logic [31:0] iwdata = '0;
   logic        oready, ovalid, oerr, omem_wen;
   logic [31:0] ordata, omem_pos, omem_wdata, imem_rdata;
   logic [1:0]  omem_be;

   load_store_unit #(.MP_WIDTH(32)) dut (
      .iclk(iclk), .irst(irst), .ivalid(ivalid), .oready(oready), .iwe(iwe),
      .ifunct3(ifunct3), .iaddr(iaddr), .iwdata(iwdata), .ovalid(ovalid),
      .ordata(ordata), .oerr(oerr), .omem_pos(omem_pos), .omem_wen(omem_wen),
      .omem_be(omem_be), .omem_wdata(omem_wdata), .imem_rdata(imem_rdata)
   );

   always #5 iclk = ~iclk;

   typedef struct {logic err; logic [31:0] data; int cyc;} resp_t;
   typedef struct {logic [31:0] pos; logic [1:0] be; logic [31:0] wdata;} wr_t;

   resp_t rq[$];
   wr_t   wq[$];
   resp_t mr;
   wr_t   mw;
   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   logic [7:0] mem [0:255];

   always @(posedge iclk) cyc <= cyc + 1;

   always @(posedge iclk) begin
      if (omem_wen) begin
         mem[omem_pos[7:0]] <= omem_wdata[7:0];
         if (omem_be != 2'b00) mem[omem_pos[7:0] + 8'd1] <= omem_wdata[15:8];
         if (omem_be == 2'b10) begin
            mem[omem_pos[7:0] + 8'd2] <= omem_wdata[23:16];
            mem[omem_pos[7:0] + 8'd3] <= omem_wdata[31:24];
         end
      end
   end

   always_comb begin
      imem_rdata = {mem[{omem_pos[7:2], 2'd3}], mem[{omem_pos[7:2], 2'd2}],
                    mem[{omem_pos[7:2], 2'd1}], mem[{omem_pos[7:2], 2'd0}]};
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   always @(negedge iclk) begin
      if (ovalid) begin
         if (rq.size() == 0) chk("unexpected_ovalid", 32'd1, 32'd0);
         else begin
            mr = rq.pop_front();
            chk("ordata", ordata, mr.data);
            chk("oerr", {31'd0, oerr}, {31'd0, mr.err});
            chk("latency_cycle", cyc, mr.cyc);
         end
      end
      if (omem_wen) begin
         if (wq.size() == 0) chk("unexpected_write", omem_pos, 32'hFFFF_FFFF);
         else begin
            mw = wq.pop_front();
            chk("wr_pos", omem_pos, mw.pos);
            chk("wr_be", {30'd0, omem_be}, {30'd0, mw.be});
            chk("wr_data", omem_wdata, mw.wdata);
         end
      end
   end

   task automatic wait_ready();
      int n = 0;
      @(negedge iclk);
      while (!oready && n < 30) begin
         @(negedge iclk);
         n++;
      end
      if (!oready) chk("oready_timeout", 32'd0, 32'd1);
   endtask

   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic err, input logic [31:0] data,
                        input int lat);
      resp_t r;
      wait_ready();
      ivalid = 1'b1; iwe = we; ifunct3 = f3; iaddr = addr; iwdata = wd;
      @(posedge iclk);
      #1;
      ivalid = 1'b0;
      r.err = err; r.data = data; r.cyc = cyc + lat - 1;
      rq.push_back(r);
   endtask

   task automatic exp_wr(input logic [31:0] pos, input logic [1:0] be, input logic [31:0] wd);
      wr_t w;
      w.pos = pos; w.be = be; w.wdata = wd;
      wq.push_back(w);
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) @(posedge iclk);
      @(negedge iclk);
      chk("rst_oready", {31'd0, oready}, 32'd0);
      chk("rst_ovalid", {31'd0, ovalid}, 32'd0);
      chk("rst_oerr", {31'd0, oerr}, 32'd0);
      chk("rst_ordata", ordata, 32'd0);
      chk("rst_wen", {31'd0, omem_wen}, 32'd0);
      @(posedge iclk); #1 irst = 1'b0;
      @(negedge iclk);
      chk("post_rst_oready", {31'd0, oready}, 32'd1);

      exp_wr(32'h10, 2'b10, 32'hDEADBEEF);
      issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 2);
      issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 2);

      exp_wr(32'h10, 2'b10, 32'h80FF7F01);
      issue(1'b1, 3'b010, 32'h10, 32'h80FF7F01, 1'b0, 32'h0, 2);
      issue(1'b0, 3'b000, 32'h11, 32'h0, 1'b0, 32'h0000007F, 2);
      issue(1'b0, 3'b000, 32'h12, 32'h0, 1'b0, 32'hFFFFFFFF, 2);
      issue(1'b0, 3'b100, 32'h13, 32'h0, 1'b0, 32'h00000080, 2);
      issue(1'b0, 3'b001, 32'h12, 32'h0, 1'b0, 32'hFFFF80FF, 2);
      issue(1'b0, 3'b101, 32'h12, 32'h0, 1'b0, 32'h000080FF, 2);

      exp_wr(32'h21, 2'b00, 32'h44);
      exp_wr(32'h22, 2'b00, 32'h33);
      exp_wr(32'h23, 2'b00, 32'h22);
      exp_wr(32'h24, 2'b00, 32'h11);
      issue(1'b1, 3'b010, 32'h21, 32'h11223344, 1'b0, 32'h0, 5);
      issue(1'b0, 3'b010, 32'h21, 32'h0, 1'b0, 32'h11223344, 5);

      exp_wr(32'h33, 2'b00, 32'h5A);
      exp_wr(32'h34, 2'b00, 32'hA5);
      issue(1'b1, 3'b001, 32'h33, 32'h0000A55A, 1'b0, 32'h0, 3);
      issue(1'b0, 3'b101, 32'h33, 32'h0, 1'b0, 32'h0000A55A, 3);
      issue(1'b0, 3'b001, 32'h33, 32'h0, 1'b0, 32'hFFFFA55A, 3);

      issue(1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0, 1);
      issue(1'b1, 3'b100, 32'h10, 32'h12345678, 1'b1, 32'h0, 1);

      // Abort a serial store after its second byte; nothing else may follow
      exp_wr(32'h41, 2'b00, 32'hBE);
      exp_wr(32'h42, 2'b00, 32'hBA);
      wait_ready();
      ivalid = 1'b1; iwe = 1'b1; ifunct3 = 3'b010; iaddr = 32'h41; iwdata = 32'hCAFEBABE;
      @(posedge iclk); #1 ivalid = 1'b0;
      @(posedge iclk);
      @(posedge iclk); #1 irst = 1'b1;
      @(negedge iclk);
      chk("inrst_oready", {31'd0, oready}, 32'd0);
      chk("inrst_wen", {31'd0, omem_wen}, 32'd0);
      repeat (2) @(posedge iclk);
      #1 irst = 1'b0;
      @(negedge iclk);
      chk("abort_oready", {31'd0, oready}, 32'd1);
      repeat (8) @(negedge iclk);
      chk("mem_41", {24'd0, mem[8'h41]}, 32'hBE);
      chk("mem_42", {24'd0, mem[8'h42]}, 32'hBA);
      chk("resp_queue_left", rq.size(), 32'd0);
      chk("write_queue_left", wq.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
